// File: rtl/psram_pkg.sv
// Shared types and constants for the quad-SPI PSRAM host controller.
package psram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_GAP
  } psram_st_t;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam int CMD_BITS     = 8;
  localparam int ADDR_NIBBLES = 6;
  localparam int RD_NIBBLES   = 8;

  // Byte 0 travels first on the wire, so the shift register holds words byte-reversed.
  function automatic logic [31:0] byteSwap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [7:0] wrNibbles(input logic [1:0] size);
    case (size)
      2'd0:    return 8'd2;
      2'd1:    return 8'd4;
      default: return 8'd8;
    endcase
  endfunction

endpackage

// File: rtl/psram_ctrl_shifter.sv
// Loadable 32-bit shift register: MSB-first 1- or 4-bit shift-out, 4-bit shift-in,
// with a byte-swapped word view so received nibbles come out in host byte order.
module psram_ctrl_shifter
  import psram_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        shift_i,
  input  logic        nibble_i,
  input  logic [3:0]  shift_in_i,
  output logic [3:0]  top_o,
  output logic [31:0] word_o
);

  logic [31:0] shiftReg_q;
  logic [31:0] shiftReg_d;

  always_comb begin
    shiftReg_d = shiftReg_q;
    if (load_i) begin
      shiftReg_d = load_data_i;
    end else if (shift_i) begin
      shiftReg_d = nibble_i ? {shiftReg_q[27:0], shift_in_i} : {shiftReg_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shiftReg_q <= '0;
    end else begin
      shiftReg_q <= shiftReg_d;
    end
  end

  assign top_o  = shiftReg_q[31:28];
  assign word_o = byteSwap(shiftReg_q);

endmodule

// File: rtl/psram_ctrl.sv
// QSPI host controller: single-beat quad read (EBh) / quad write (38h) with sck = clock/2.
module psram_ctrl
  import psram_pkg::*;
#(
  parameter int WAIT_CYCLES = 6,
  parameter int CE_GAP      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        sck,
  output logic        ce_n,
  output logic [3:0]  dio_o,
  output logic [3:0]  dio_oe,
  input  logic [3:0]  dio_i
);

  psram_st_t   state_q;
  logic        we_q;
  logic [23:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q;
  logic        sck_q;
  logic        ceN_q;
  logic        respValid_q;
  logic [3:0]  dioO_q;
  logic [3:0]  dioOe_q;
  logic [31:0] rdata_q;

  logic        active;
  logic        riseEdge;
  logic        fallEdge;
  logic        lastRise;
  logic        dataDone;
  logic [7:0]  phaseRises;
  logic        shLoad;
  logic        shShift;
  logic        shNibble;
  logic [31:0] shLoadData;
  logic [31:0] shWord;
  logic [3:0]  shTop;

  // With ce_n still high in CMD the first edge is the fall that presents the first bit.
  always_comb begin
    active   = state_q inside {ST_CMD, ST_ADDR, ST_WAIT, ST_RDATA, ST_WDATA};
    riseEdge = active && !ceN_q && !sck_q;
    fallEdge = active && (sck_q || ceN_q);
    case (state_q)
      ST_CMD:   phaseRises = 8'(CMD_BITS);
      ST_ADDR:  phaseRises = 8'(ADDR_NIBBLES);
      ST_WAIT:  phaseRises = 8'(WAIT_CYCLES + 1);
      ST_RDATA: phaseRises = 8'(RD_NIBBLES);
      ST_WDATA: phaseRises = wrNibbles(size_q);
      default:  phaseRises = 8'd0;
    endcase
    lastRise = riseEdge && (cnt_q == phaseRises - 8'd1);
    dataDone = fallEdge && (state_q inside {ST_RDATA, ST_WDATA}) && (cnt_q == phaseRises);
  end

  // Each phase's shift register contents are loaded on the last rise of the previous phase.
  always_comb begin
    shLoad     = 1'b0;
    shLoadData = '0;
    shShift    = 1'b0;
    shNibble   = 1'b1;
    if (state_q == ST_IDLE && req_valid) begin
      shLoad     = 1'b1;
      shLoadData = {(req_we ? CMD_QWRITE : CMD_QREAD), 24'h0};
    end else if (lastRise && state_q == ST_CMD) begin
      shLoad     = 1'b1;
      shLoadData = {addr_q, 8'h00};
    end else if (lastRise && state_q == ST_ADDR) begin
      shLoad     = 1'b1;
      shLoadData = byteSwap(wdata_q);
    end else if (riseEdge && state_q == ST_RDATA) begin
      shShift = 1'b1;
    end else if (fallEdge && !dataDone && (state_q inside {ST_CMD, ST_ADDR, ST_WDATA})) begin
      shShift  = 1'b1;
      shNibble = (state_q != ST_CMD);
    end
  end

  psram_ctrl_shifter u_shifter (
    .clock       (clock),
    .reset       (reset),
    .load_i      (shLoad),
    .load_data_i (shLoadData),
    .shift_i     (shShift),
    .nibble_i    (shNibble),
    .shift_in_i  (dio_i),
    .top_o       (shTop),
    .word_o      (shWord)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      sck_q       <= 1'b0;
      ceN_q       <= 1'b1;
      respValid_q <= 1'b0;
      dioO_q      <= '0;
      dioOe_q     <= '0;
      rdata_q     <= '0;
    end else begin
      respValid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            cnt_q   <= '0;
            state_q <= ST_CMD;
          end
        end
        ST_GAP: begin
          if (cnt_q == 8'(CE_GAP - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          if (riseEdge) begin
            sck_q <= 1'b1;
            if (lastRise && state_q == ST_CMD) begin
              cnt_q   <= '0;
              state_q <= ST_ADDR;
            end else if (lastRise && state_q == ST_ADDR) begin
              cnt_q   <= '0;
              state_q <= we_q ? ST_WDATA : ST_WAIT;
            end else if (lastRise && state_q == ST_WAIT) begin
              cnt_q   <= '0;
              state_q <= ST_RDATA;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end else if (dataDone) begin
            sck_q       <= 1'b0;
            ceN_q       <= 1'b1;
            dioO_q      <= '0;
            dioOe_q     <= '0;
            respValid_q <= 1'b1;
            rdata_q     <= we_q ? 32'h0 : shWord;
            cnt_q       <= '0;
            state_q     <= ST_GAP;
          end else begin
            sck_q <= 1'b0;
            ceN_q <= 1'b0;
            case (state_q)
              ST_CMD: begin
                dioO_q  <= {3'b000, shTop[3]};
                dioOe_q <= 4'b0001;
              end
              ST_ADDR, ST_WDATA: begin
                dioO_q  <= shTop;
                dioOe_q <= 4'b1111;
              end
              default: begin
                dioO_q  <= 4'h0;
                dioOe_q <= 4'b0000;
              end
            endcase
          end
        end
      endcase
    end
  end

  // Size 3 is not a legal write length; it still runs as a 4-byte burst.
  assert property (@(posedge clock) disable iff (reset)
    (req_valid && req_ready && req_we) |-> (req_size != 2'd3));

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = respValid_q;
  assign resp_rdata = rdata_q;
  assign sck        = sck_q;
  assign ce_n       = ceN_q;
  assign dio_o      = dioO_q;
  assign dio_oe     = dioOe_q;

endmodule

// File: tb/tb_psram_ctrl.sv
// Bench for psram_ctrl: PSRAM device model on the pins, scoreboard of expected responses
// and per-rise capture of what the controller drives.
module tb_psram_ctrl;

  localparam int WAIT_CYCLES = 6;
  localparam int CE_GAP      = 2;
  localparam int FIRST_DRIVE = 8 + 6 + WAIT_CYCLES + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [23:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        sck;
  logic        ce_n;
  logic [3:0]  dio_o;
  logic [3:0]  dio_oe;
  logic [3:0]  dio_i = 4'h0;

  always #5 clock = ~clock;

  psram_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .CE_GAP(CE_GAP)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .sck        (sck),
    .ce_n       (ce_n),
    .dio_o      (dio_o),
    .dio_oe     (dio_oe),
    .dio_i      (dio_i)
  );

  typedef struct {
    bit          we;
    logic [31:0] rdata;
    int          latency;
  } exp_t;

  exp_t        expQ[$];
  int          acceptQ[$];
  exp_t        curExp;
  int          curAccept;
  int          assertCount = 0;
  int          failCount = 0;
  int          cycle = 0;
  int          acceptCount = 0;
  int          respCount = 0;
  int          riseCnt = 0;
  int          ceHigh = 0;
  int          minGap = 1000;
  int          readyBad = 0;
  int          sckIdle = 0;
  bit          trackGap = 1'b0;
  logic [3:0]  riseDo[64];
  logic [3:0]  riseOe[64];
  logic        prevSck = 1'b0;
  logic        prevCe = 1'b1;
  logic [31:0] devWord = '0;
  int          devRise = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int bytesFor(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic int riseTotal(input bit we, input logic [1:0] size);
    return we ? (14 + 2 * bytesFor(size)) : (14 + WAIT_CYCLES + 1 + 8);
  endfunction

  always @(posedge clock) cycle <= cycle + 1;

  // Device model: loads nibble 0 on the turnaround rise, then one nibble per rise, byte0 high nibble first.
  always @(posedge sck or posedge ce_n) begin
    if (ce_n) begin
      devRise = 0;
      dio_i   = 4'h0;
    end else begin
      devRise = devRise + 1;
      if (devRise >= FIRST_DRIVE && devRise < FIRST_DRIVE + 8)
        dio_i = devWord[8 * ((devRise - FIRST_DRIVE) / 2) + (((devRise - FIRST_DRIVE) % 2 == 0) ? 4 : 0) +: 4];
      else
        dio_i = 4'h0;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      acceptQ.delete();
      riseCnt = 0;
    end else begin
      if (!ce_n && prevCe) begin
        if (trackGap && ceHigh < minGap) minGap = ceHigh;
        ceHigh  = 0;
        riseCnt = 0;
      end
      if (ce_n) ceHigh++;
      if (!ce_n && sck && !prevSck && riseCnt < 64) begin
        riseDo[riseCnt] = dio_o;
        riseOe[riseCnt] = dio_oe;
        riseCnt++;
      end
      if (ce_n && sck) sckIdle++;
      if (!ce_n && req_ready) readyBad++;
      if (req_valid && req_ready) begin
        acceptQ.push_back(cycle + 1);
        acceptCount++;
      end
      if (resp_valid) begin
        respCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        end else begin
          curExp    = expQ.pop_front();
          curAccept = (acceptQ.size() > 0) ? acceptQ.pop_front() : -1000;
          checkOutput("resp_latency", 32'(cycle - curAccept), 32'(curExp.latency));
          checkOutput("ce_n_at_resp", 32'(ce_n), 32'd1);
          checkOutput("sck_at_resp", 32'(sck), 32'd0);
          if (!curExp.we) checkOutput("resp_rdata", resp_rdata, curExp.rdata);
        end
      end
    end
    prevSck = sck;
    prevCe  = ce_n;
  end

  task automatic checkFrame(input bit we, input logic [23:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    logic [7:0] cmd;
    logic [3:0] nib;
    int         nRises;
    int         b;
    cmd    = we ? 8'h38 : 8'hEB;
    nRises = riseTotal(we, size);
    checkOutput("rise_count", 32'(riseCnt), 32'(nRises));
    if (riseCnt == nRises) begin
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("cmd_rise%0d", i + 1), {24'd0, riseOe[i], riseDo[i]}, {24'd0, 4'b0001, 3'b000, cmd[7-i]});
      for (int j = 0; j < 6; j++) begin
        nib = addr[23 - 4*j -: 4];
        checkOutput($sformatf("addr_nib%0d", j), {24'd0, riseOe[8+j], riseDo[8+j]}, {24'd0, 4'hF, nib});
      end
      if (!we) begin
        for (int i = 14; i < nRises; i++)
          checkOutput($sformatf("rd_oe_rise%0d", i + 1), 32'(riseOe[i]), 32'd0);
      end else begin
        for (int k = 0; k < 2 * bytesFor(size); k++) begin
          b   = k / 2;
          nib = (k % 2 == 0) ? wdata[8*b + 4 +: 4] : wdata[8*b +: 4];
          checkOutput($sformatf("wr_nib%0d", k), {24'd0, riseOe[14+k], riseDo[14+k]}, {24'd0, 4'hF, nib});
        end
      end
    end
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("ready_before_req", 32'(req_ready), 32'd1);
  endtask

  task automatic applyStimulus(input bit we, input logic [23:0] addr, input logic [1:0] size,
                               input logic [31:0] wdata, input logic [31:0] word);
    int   baseAcc;
    int   baseResp;
    int   n;
    exp_t e;
    waitReady();
    devWord   = word;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    e.we      = we;
    e.rdata   = word;
    e.latency = 2 * riseTotal(we, size) + 1;
    expQ.push_back(e);
    baseAcc  = acceptCount;
    baseResp = respCount;
    n = 0;
    while (acceptCount == baseAcc && n < 100) begin
      @(negedge clock); #1;
      n++;
    end
    checkOutput("accept_seen", 32'(acceptCount - baseAcc), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (respCount == baseResp && n < 200) begin
      @(negedge clock); #1;
      n++;
    end
    checkOutput("resp_seen", 32'(respCount - baseResp), 32'd1);
    checkFrame(we, addr, size, wdata);
  endtask

  initial begin
    int   baseAcc;
    int   baseResp;
    int   n;
    exp_t e;

    repeat (3) @(negedge clock);
    checkOutput("rst_ce_n", 32'(ce_n), 32'd1);
    checkOutput("rst_sck", 32'(sck), 32'd0);
    checkOutput("rst_dio_oe", 32'(dio_oe), 32'd0);
    checkOutput("rst_dio_o", 32'(dio_o), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;

    applyStimulus(1'b0, 24'h000123, 2'd0, 32'h0, 32'hDEADBEEF);
    applyStimulus(1'b1, 24'h000040, 2'd2, 32'h11223344, 32'h0);
    applyStimulus(1'b1, 24'hABCDEF, 2'd0, 32'h000000A5, 32'h0);
    applyStimulus(1'b1, 24'h5A5A5A, 2'd1, 32'h0000BEEF, 32'h0);
    applyStimulus(1'b0, 24'hFEDCBA, 2'd0, 32'h0, 32'h01234567);

    // Back-to-back reads with req_valid held across both frames.
    waitReady();
    devWord   = 32'hCAFEF00D;
    req_we    = 1'b0;
    req_addr  = 24'h100200;
    req_valid = 1'b1;
    e.we      = 1'b0;
    e.rdata   = 32'hCAFEF00D;
    e.latency = 2 * riseTotal(1'b0, 2'd0) + 1;
    expQ.push_back(e);
    expQ.push_back(e);
    trackGap = 1'b1;
    minGap   = 1000;
    readyBad = 0;
    baseAcc  = acceptCount;
    baseResp = respCount;
    n = 0;
    while (acceptCount < baseAcc + 2 && n < 300) begin
      @(negedge clock); #1;
      n++;
    end
    checkOutput("b2b_accepts", 32'(acceptCount - baseAcc), 32'd2);
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (respCount < baseResp + 2 && n < 200) begin
      @(negedge clock); #1;
      n++;
    end
    trackGap = 1'b0;
    checkOutput("b2b_resps", 32'(respCount - baseResp), 32'd2);
    checkOutput("b2b_gap_ge_min", (minGap >= CE_GAP) ? 32'd1 : 32'd0, 32'd1);
    checkOutput("b2b_ready_low_in_frame", 32'(readyBad), 32'd0);

    // Abort a read with reset at T30.
    waitReady();
    devWord   = 32'h0BADF00D;
    req_we    = 1'b0;
    req_addr  = 24'h000777;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    checkOutput("t30_ce_n_low", 32'(ce_n), 32'd0);
    checkOutput("t30_sck_high", 32'(sck), 32'd1);
    baseResp = respCount;
    reset = 1'b1;
    #1;
    checkOutput("abort_ce_n", 32'(ce_n), 32'd1);
    checkOutput("abort_sck", 32'(sck), 32'd0);
    checkOutput("abort_dio_oe", 32'(dio_oe), 32'd0);
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (80) @(posedge clock);
    #1;
    checkOutput("abort_no_resp", 32'(respCount), 32'(baseResp));
    applyStimulus(1'b0, 24'h000777, 2'd0, 32'h0, 32'h89ABCDEF);

    checkOutput("sck_quiet_when_ce_high", 32'(sckIdle), 32'd0);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/psram_ctrl.md
Name: psram_ctrl

Overview:
- Host-side QSPI controller for the team's PSRAM device model.
- Accepts single-beat read/write requests on a valid/ready bus and drives sck, ce_n and a split dio bus (out, output-enable, in); the top-level wrapper builds the tri-state pad.
- Issues quad read EBh and quad write 38h with the same framing the device decodes: 8-bit command on dio[0], 24-bit address as 6 nibbles on dio[3:0], 6 wait cycles for reads, then data nibbles.
- sck is clock/2, generated internally.

Parameters:
- WAIT_CYCLES, 6, sck rising edges in read wait phase (after address, before device drives).
- CE_GAP, 2, minimum clock cycles ce_n stays high between transactions.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = write (38h), 0 = read (EBh)
- req_addr  in  24  byte address, sent unmodified
- req_size  in  2  write length: 0 = 1B, 1 = 2B, 2 = 4B; ignored for reads (always 4B); 3 is illegal
- req_wdata  in  32  write data; byte k of the burst = req_wdata[8k+7:8k]
- resp_valid  out  1  one-cycle pulse at transaction end (read data or write ack)
- resp_rdata  out  32  read word; holds last value, 0 after reset and for writes
- sck  out  1  serial clock
- ce_n  out  1  chip enable, active-low
- dio_o  out  4  serial data out
- dio_oe  out  4  per-bit output enable
- dio_i  in  4  serial data in

Behaviour:
- Reset (async): ce_n = 1, sck = 0, dio_oe = 0, dio_o = 0, resp_valid = 0, resp_rdata = 0, req_ready = 1, state IDLE. Reset mid-transaction aborts immediately; no resp_valid.
- Two-phase sck, alternating clock edges:
  - Fall edge: sck <= 0; controller updates dio_o and dio_oe.
  - Rise edge: sck <= 1; controller samples dio_i (value before the device's own posedge update).
  - Edge counter counts sck rises within the current phase.
- States: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, GAP.
- IDLE:
  - Accept on clock edge T0 with req_valid & req_ready.
  - Latch we/addr/size/wdata; req_ready drops at T0.
  - At T1: ce_n = 0, sck = 0, CMD begins.
- CMD: 8 rises.
  - dio_oe = 0001; dio_o[0] = cmd bit, MSB first; dio_o[3:1] = 0.
  - Rise k occurs at T(2k).
- ADDR: 6 rises, dio_oe = 1111, addr[23:20] first, addr[3:0] last.
- Read path:
  - WAIT: WAIT_CYCLES rises with dio_oe = 0.
  - Then 1 turnaround rise (the device loads its first nibble).
  - RDATA: 8 rises, dio_oe = 0; sampled nibbles n0..n7.
  - Assembly: resp_rdata = {n6,n7,n4,n5,n2,n3,n0,n1}, i.e. byte0 = {n0,n1}, high nibble first.
  - With defaults, last rise at T58.
- Write path:
  - WDATA: 2 × bytes rises, dio_oe = 1111.
  - Per byte, high nibble then low nibble, byte0 first.
  - 4-byte write: last rise at T44.
- End of transaction (clock edge after last rise):
  - sck = 0, ce_n = 1, dio_oe = 0.
  - resp_valid = 1 for exactly that cycle; resp_rdata updated on reads.
  - Enter GAP.
- GAP: CE_GAP cycles, then IDLE; req_ready = 1. A new request never starts with ce_n high for fewer than CE_GAP cycles.
- req_size = 3: treated as 4B; a simulation assertion fires.
- sck never toggles while ce_n = 1; ce_n only changes while sck = 0.
- No backpressure on resp; req_valid held during a transaction is not re-accepted until IDLE.

Decomposition:
- Package psram_pkg:
  - state enum psram_st_t
  - CMD_QREAD = 8'hEB, CMD_QWRITE = 8'h38
  - CMD_BITS = 8, ADDR_NIBBLES = 6
  - RD_NIBBLES = 8
- One sub-module, psram_ctrl_shifter: loadable 32-bit shift register, 1- or 4-bit shift-out and 4-bit shift-in with nibble reorder; shared by CMD/ADDR/WDATA/RDATA.

Test Plan:
- Read addr 0x000123, device word 0xDEADBEEF:
  - dio_o[0] bits 1,1,1,0,1,0,1,1 on rises 1-8.
  - Address nibbles 0,0,0,1,2,3.
  - resp_valid at T59 with resp_rdata = 0xDEADBEEF; ce_n high at T59.
- Write size 2, addr 0x000040, wdata 0x11223344:
  - 38h on dio[0].
  - Nibbles 4,4,3,3,2,2,1,1 on rises 15-22.
  - resp_valid at T45.
- Write size 0, wdata 0x000000A5: exactly 16 rises (nibbles A, 5); ce_n high the next edge.
- Back-to-back reads with req_valid held high: ce_n high ≥ 2 cycles between frames; req_ready low throughout each frame.
- Reset asserted at T30 of a read: ce_n = 1, sck = 0, dio_oe = 0 immediately; no resp_valid; next request completes normally.
- dio_oe check across a read: 0001 in CMD, 1111 in ADDR, 0000 in WAIT/RDATA; never 1111 while the device is driving.
